// File: rtl/alu_pkg.sv
// ALU control codes shared by the decoder, the arbiter and the CNN issue path,
// plus the legality check applied to CNN-issued codes.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SNE = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b1100;

    function automatic logic is_legal_aluctl(input logic [3:0] ctl);
        case (ctl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL,
            ALU_SUB, ALU_SLT, ALU_SNE, ALU_XOR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rsp_buf.sv
// One-entry registered response slot for CNN results (data + illegal-code flag).
// Handshake: an entry transfers out on any cycle where rsp_valid & rsp_ready are both high.
module alu_rsp_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_err,
    input  logic             rsp_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;

    // A load in the same cycle as a consume replaces the entry and keeps it valid.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            err_d   = load_err;
        end else if (rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the pipeline EX stage and the CNN issue port: the
// pipeline wins by default, the CNN is force-granted after MAX_WAIT refusals.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_req,
    input  logic [3:0]       pipe_aluctl,
    input  logic [WIDTH-1:0] pipe_a,
    input  logic [WIDTH-1:0] pipe_b,
    output logic             pipe_stall,
    output logic [WIDTH-1:0] pipe_result,
    output logic             pipe_zero,
    input  logic             cnn_valid,
    output logic             cnn_ready,
    input  logic [3:0]       cnn_aluctl,
    input  logic [WIDTH-1:0] cnn_a,
    input  logic [WIDTH-1:0] cnn_b,
    output logic             cnn_rsp_valid,
    input  logic             cnn_rsp_ready,
    output logic [WIDTH-1:0] cnn_rsp_data,
    output logic             cnn_rsp_err,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic [3:0]       dbg_wait_cnt
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic             buf_free;
    logic             force_gnt;
    logic             cnn_gnt;
    logic             cnn_legal;
    logic [WIDTH-1:0] rsp_load_data;

    // The buffer may be reloaded in the same cycle its current entry is consumed.
    always_comb begin
        buf_free  = !cnn_rsp_valid || cnn_rsp_ready;
        force_gnt = (wait_cnt_q == MAX_WAIT_C) && cnn_valid && buf_free;
        cnn_gnt   = cnn_valid && buf_free && (force_gnt || !pipe_req);
        cnn_legal = is_legal_aluctl(cnn_aluctl);
    end

    assign cnn_ready  = cnn_gnt;
    assign pipe_stall = pipe_req && cnn_gnt;

    // Illegal CNN codes run as ADD so the ALU never sees an undefined control.
    always_comb begin
        alu_ctl = pipe_aluctl;
        alu_a   = pipe_a;
        alu_b   = pipe_b;
        if (cnn_gnt) begin
            alu_ctl = cnn_legal ? cnn_aluctl : ALU_ADD;
            alu_a   = cnn_a;
            alu_b   = cnn_b;
        end
    end

    assign pipe_result = alu_y;
    assign pipe_zero   = alu_zero;

    // A saturated count with a full buffer simply holds until the buffer drains.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (cnn_gnt || !cnn_valid) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign dbg_wait_cnt  = wait_cnt_q;
    assign rsp_load_data = cnn_legal ? alu_y : '0;

    alu_rsp_buf #(
        .WIDTH(WIDTH)
    ) u_rsp_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnn_gnt),
        .load_data(rsp_load_data),
        .load_err (!cnn_legal),
        .rsp_ready(cnn_rsp_ready),
        .rsp_valid(cnn_rsp_valid),
        .rsp_data (cnn_rsp_data),
        .rsp_err  (cnn_rsp_err)
    );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a behavioural ALU drives alu_y, a
// streak-based arbitration model is checked every negedge, plus literal checks.
module tb_alu_share_arbiter;
  localparam int W  = 32;
  localparam int MW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pipe_req = 1'b0;
  logic [3:0]   pipe_aluctl = 4'd0;
  logic [W-1:0] pipe_a = '0;
  logic [W-1:0] pipe_b = '0;
  logic         pipe_stall;
  logic [W-1:0] pipe_result;
  logic         pipe_zero;
  logic         cnn_valid = 1'b0;
  logic         cnn_ready;
  logic [3:0]   cnn_aluctl = 4'd0;
  logic [W-1:0] cnn_a = '0;
  logic [W-1:0] cnn_b = '0;
  logic         cnn_rsp_valid;
  logic         cnn_rsp_ready = 1'b0;
  logic [W-1:0] cnn_rsp_data;
  logic         cnn_rsp_err;
  logic [3:0]   alu_ctl;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_y;
  logic         alu_zero;
  logic [3:0]   dbg_wait_cnt;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_req(pipe_req), .pipe_aluctl(pipe_aluctl), .pipe_a(pipe_a), .pipe_b(pipe_b),
    .pipe_stall(pipe_stall), .pipe_result(pipe_result), .pipe_zero(pipe_zero),
    .cnn_valid(cnn_valid), .cnn_ready(cnn_ready), .cnn_aluctl(cnn_aluctl),
    .cnn_a(cnn_a), .cnn_b(cnn_b),
    .cnn_rsp_valid(cnn_rsp_valid), .cnn_rsp_ready(cnn_rsp_ready),
    .cnn_rsp_data(cnn_rsp_data), .cnn_rsp_err(cnn_rsp_err),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_zero(alu_zero), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // ---------------- behavioural ALU ----------------
  function automatic logic [W-1:0] alu_ref(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a << b[4:0];
      4'd4:    return a >> b[4:0];
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return (a != b) ? 32'd1 : 32'd0;
      4'd12:   return a ^ b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_y    = alu_ref(alu_ctl, alu_a, alu_b);
    alu_zero = (alu_y == '0);
  end

  function automatic logic legal(input logic [3:0] c);
    return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd12};
  endfunction

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: refusal streak + one response slot ----------------
  int           m_refused;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_err;

  function automatic logic m_gnt();
    logic room;
    room = !m_valid || cnn_rsp_ready;
    return cnn_valid && room && (!pipe_req || (m_refused >= MW));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_refused <= 0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_err     <= 1'b0;
    end else if (m_gnt()) begin
      m_refused <= 0;
      m_valid   <= 1'b1;
      m_data    <= legal(cnn_aluctl) ? alu_ref(cnn_aluctl, cnn_a, cnn_b) : '0;
      m_err     <= !legal(cnn_aluctl);
    end else begin
      if (cnn_rsp_ready) m_valid <= 1'b0;
      m_refused <= cnn_valid ? m_refused + 1 : 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic         g;
    logic [3:0]   ectl;
    logic [W-1:0] ea, eb, ey;
    logic [31:0]  ew;
    g    = m_gnt();
    ectl = g ? (legal(cnn_aluctl) ? cnn_aluctl : 4'd2) : pipe_aluctl;
    ea   = g ? cnn_a : pipe_a;
    eb   = g ? cnn_b : pipe_b;
    ey   = alu_ref(ectl, ea, eb);
    ew   = (m_refused < MW) ? 32'(m_refused) : 32'(MW);
    chk("cnn_ready", 32'(cnn_ready), 32'(g));
    chk("pipe_stall", 32'(pipe_stall), 32'(pipe_req & g));
    chk("alu_ctl", 32'(alu_ctl), 32'(ectl));
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("pipe_result", pipe_result, ey);
    chk("pipe_zero", 32'(pipe_zero), 32'(ey == '0));
    chk("rsp_valid", 32'(cnn_rsp_valid), 32'(m_valid));
    chk("rsp_data", cnn_rsp_data, m_data);
    chk("rsp_err", 32'(cnn_rsp_err), 32'(m_err));
    chk("wait_cnt", 32'(dbg_wait_cnt), ew);
  end

  // ---------------- driver ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", 32'(cnn_rsp_valid), 32'd0);
    chk("rst_data", cnn_rsp_data, 32'd0);
    chk("rst_err", 32'(cnn_rsp_err), 32'd0);
    chk("rst_wait", 32'(dbg_wait_cnt), 32'd0);
    chk("rst_ready", 32'(cnn_ready), 32'd0);
    next();
    rst_n = 1'b1;

    // pipeline only
    pipe_req = 1'b1; pipe_aluctl = 4'b0010; pipe_a = 32'd5; pipe_b = 32'd7;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("pipe_only_result", pipe_result, 32'd12);
      chk("pipe_only_stall", 32'(pipe_stall), 32'd0);
      chk("pipe_only_ready", 32'(cnn_ready), 32'd0);
      next();
    end

    // CNN only: 9-4
    pipe_req = 1'b0; cnn_valid = 1'b1; cnn_aluctl = 4'b0110; cnn_a = 32'd9; cnn_b = 32'd4;
    cnn_rsp_ready = 1'b1;
    #2 chk("cnn_only_ready", 32'(cnn_ready), 32'd1);
    next();
    cnn_valid = 1'b0;
    #2;
    chk("cnn_only_rsp_valid", 32'(cnn_rsp_valid), 32'd1);
    chk("cnn_only_rsp_data", cnn_rsp_data, 32'd5);
    chk("cnn_only_rsp_err", 32'(cnn_rsp_err), 32'd0);
    next();

    // starvation: grant on every fifth cycle
    pipe_req = 1'b1; cnn_valid = 1'b1; cnn_aluctl = 4'b0010; cnn_a = 32'd1; cnn_b = 32'd2;
    cnn_rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("starve_ready", 32'(cnn_ready), 32'((i % 5) == 4));
      chk("starve_stall", 32'(pipe_stall), 32'((i % 5) == 4));
      next();
    end

    // backpressure: drain, fill, then hold the buffer full
    cnn_valid = 1'b0; pipe_req = 1'b0;
    next();
    cnn_valid = 1'b1; cnn_aluctl = 4'b0001; cnn_a = 32'hF0; cnn_b = 32'h0F; cnn_rsp_ready = 1'b0;
    #2 chk("bp_fill_ready", 32'(cnn_ready), 32'd1);
    next();
    cnn_aluctl = 4'b1100; cnn_a = 32'hFF; cnn_b = 32'h0F;
    for (int i = 0; i < 6; i++) begin
      #2 chk("bp_blocked_ready", 32'(cnn_ready), 32'd0);
      next();
    end
    #2;
    chk("bp_wait_sat", 32'(dbg_wait_cnt), 32'd4);
    chk("bp_old_data", cnn_rsp_data, 32'hFF);
    cnn_rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(cnn_ready), 32'd1);
    next();
    cnn_valid = 1'b0; cnn_rsp_ready = 1'b0;
    #2;
    chk("bp_new_data", cnn_rsp_data, 32'hF0);
    chk("bp_new_valid", 32'(cnn_rsp_valid), 32'd1);
    chk("bp_wait_clear", 32'(dbg_wait_cnt), 32'd0);
    next();

    // illegal CNN code
    cnn_valid = 1'b1; cnn_aluctl = 4'b0101; cnn_a = 32'd3; cnn_b = 32'd3; cnn_rsp_ready = 1'b1;
    #2;
    chk("ill_ready", 32'(cnn_ready), 32'd1);
    chk("ill_alu_ctl", 32'(alu_ctl), 32'd2);
    next();
    cnn_valid = 1'b0; cnn_rsp_ready = 1'b0;
    #2;
    chk("ill_rsp_valid", 32'(cnn_rsp_valid), 32'd1);
    chk("ill_rsp_data", cnn_rsp_data, 32'd0);
    chk("ill_rsp_err", 32'(cnn_rsp_err), 32'd1);
    next();

    // async reset with a full buffer and wait_cnt=3
    pipe_req = 1'b1; cnn_valid = 1'b1; cnn_aluctl = 4'b0010;
    for (int i = 0; i < 3; i++) next();
    #2;
    chk("pre_rst_wait", 32'(dbg_wait_cnt), 32'd3);
    chk("pre_rst_valid", 32'(cnn_rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(cnn_rsp_valid), 32'd0);
    chk("mid_rst_data", cnn_rsp_data, 32'd0);
    chk("mid_rst_err", 32'(cnn_rsp_err), 32'd0);
    chk("mid_rst_wait", 32'(dbg_wait_cnt), 32'd0);
    chk("mid_rst_ready", 32'(cnn_ready), 32'd0);
    next();
    rst_n = 1'b1;

    // every CNN code through an idle pipeline
    pipe_req = 1'b0; cnn_valid = 1'b1; cnn_rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cnn_aluctl = 4'(c);
      cnn_a = 32'h8000_00F3 + 32'(c);
      cnn_b = 32'(c + 1);
      next();
    end

    // mixed contention table, checked by the per-cycle model
    for (int i = 0; i < 30; i++) begin
      pipe_req      = (i % 3) != 0;
      cnn_valid     = (i % 4) != 1;
      cnn_rsp_ready = (i % 5) != 2;
      pipe_aluctl   = 4'((i * 5) % 16);
      pipe_a        = 32'(i * 37);
      pipe_b        = 32'(i * 11 + 3);
      cnn_aluctl    = 4'((i * 7) % 16);
      cnn_a         = 32'(1000 - i * 13);
      cnn_b         = 32'(i);
      next();
    end

    cnn_valid = 1'b0; pipe_req = 1'b0;
    next();
    next();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single execute-stage ALU between two requesters: the pipeline EX stage and the CNN coprocessor issue port.
- The pipeline has default priority. The CNN is guaranteed a slot after a bounded wait, enforced by stalling the pipeline.
- CNN results return through a one-entry registered response buffer with a valid/ready handshake.
- The block sits between the EX-stage control (downstream of the ALU control decoder) and the ALU operand/control muxes.

Parameters:
- WIDTH, 32, operand/result width.
- MAX_WAIT, 4, maximum consecutive cycles a pending CNN request may be refused before a forced grant; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pipe_req  in  1  EX stage needs the ALU this cycle
- pipe_aluctl  in  4  ALU control code from the decoder
- pipe_a, pipe_b  in  WIDTH  pipeline operands
- pipe_stall  out  1  pipeline must hold EX this cycle
- pipe_result  out  WIDTH  ALU result to pipeline, combinational
- pipe_zero  out  1  ALU zero flag to pipeline
- cnn_valid  in  1  CNN op request
- cnn_ready  out  1  CNN op accepted this cycle
- cnn_aluctl  in  4  CNN ALU code
- cnn_a, cnn_b  in  WIDTH  CNN operands
- cnn_rsp_valid  out  1  response buffer full
- cnn_rsp_ready  in  1  CNN consumes response
- cnn_rsp_data  out  WIDTH  registered CNN result
- cnn_rsp_err  out  1  response came from an illegal code
- alu_ctl  out  4  shared ALU control
- alu_a, alu_b  out  WIDTH  shared ALU operands
- alu_y  in  WIDTH  shared ALU result, combinational
- alu_zero  in  1  shared ALU zero flag

Behaviour:

Reset (asynchronous, rst_n=0):
- wait_cnt=0, cnn_rsp_valid=0, cnn_rsp_data=0, cnn_rsp_err=0.
- Combinational outputs follow from the reset state: pipe_stall=pipe_req&force=0, cnn_ready=0 unless the pipeline is idle.

Definitions:
- buf_free = !cnn_rsp_valid | cnn_rsp_ready. Same-cycle pass-through is allowed.
- force = (wait_cnt==MAX_WAIT) & cnn_valid & buf_free.

Grant, combinational, one owner per cycle:
- cnn_gnt = cnn_valid & buf_free & (force | !pipe_req).
- cnn_ready = cnn_gnt.
- pipe_stall = pipe_req & cnn_gnt.

Mux:
- When cnn_gnt=1, alu_ctl/alu_a/alu_b come from the CNN inputs.
- Otherwise they come from the pipeline inputs. With no requester, the pipeline inputs are still driven.
- pipe_result=alu_y and pipe_zero=alu_zero at all times. The pipeline ignores them while stalled.

wait_cnt:
- Set to 0 on cnn_gnt or !cnn_valid.
- Else, if cnn_valid & !cnn_gnt, increment, saturating at MAX_WAIT.
- When saturated but buf_free=0, there is no forced grant; the count holds until the buffer drains.

Response buffer:
- On cnn_gnt, the next edge loads cnn_rsp_data = legal ? alu_y : 0, cnn_rsp_err = !legal, cnn_rsp_valid=1.
- Else, if cnn_rsp_ready, cnn_rsp_valid=0; data is retained.
- Latency: CNN accept to cnn_rsp_valid is 1 cycle.

Legal codes: 0000, 0001, 0010, 0011, 0100, 0110, 0111, 1000, 1100.
- An illegal CNN code is still accepted, so the handshake completes.
- The ALU is driven with 0010 instead.
- The pipeline code is never checked.

Simultaneous events:
- Accept and consume in the same cycle: the new response replaces the old one, and valid stays 1.
- cnn_valid dropping while not granted: wait_cnt clears; no protocol error is required.
- Reset mid-response: the response is discarded.

Throughput: a continuously requesting pipeline loses at most 1 cycle in every MAX_WAIT+1 to the CNN.

Decomposition:
- Shared package (alu_pkg):
  - ALU code constants ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SLL=0011, ALU_SRL=0100, ALU_SUB=0110, ALU_SLT=0111, ALU_SNE=1000, ALU_XOR=1100.
  - Function is_legal_aluctl.
- Sub-module alu_rsp_buf: one-entry valid/ready register holding data+err. The arbiter keeps the grant, wait counter and muxes.

Test Plan:
- Pipeline only: pipe_req=1, ctl 0010, a=5, b=7, cnn_valid=0 -> pipe_result=12 same cycle, pipe_stall=0, cnn_ready=0 always.
- CNN only: pipe_req=0, cnn_valid=1, ctl 0110, a=9, b=4 -> cnn_ready=1 same cycle; next cycle cnn_rsp_valid=1, data=5, err=0.
- Starvation, MAX_WAIT=4: pipe_req=1 continuously with cnn_valid=1 and rsp_ready=1 -> cnn_ready=0 for cycles 0-3 and 1 in cycle 4, pipe_stall=1 only in cycle 4; the pattern repeats every 5 cycles.
- Backpressure: rsp full, cnn_rsp_ready=0, cnn_valid=1, pipe_req=0 -> cnn_ready=0 and wait_cnt saturates at 4. Raising rsp_ready grants in the same cycle, and the new data appears next cycle.
- Illegal code 0101 from the CNN with a=3, b=3 -> accepted, alu_ctl=0010, rsp data=0, err=1.
- Async reset asserted mid-sequence with rsp_valid=1, wait_cnt=3 -> immediately rsp_valid=0, data=0, err=0, wait_cnt=0.
